// File: rtl/xoodyak_cmd_sequencer.sv
// xoodyak_cmd_sequencer
// Host-side command sequencer for the Xoodyak core. It takes one command at a
// time over a valid/ready handshake and holds opmode and input_data on the core
// until the core reports completion. It then returns the func, the captured
// text and an error flag on a valid/ready response channel. The continue bit is
// generated here, and a timeout guards against a core that never finishes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a command, core sees opmode 0
// WAIT  | command issued, opmode/data held, timeout counter running
// RESP  | response presented on rsp_*, waiting for rsp_ready
//
// Ports:
//   eph1            clock, all state on rising edge
//   reset           asynchronous active-low reset
//   cmd_valid/ready command handshake; cmd_func, cmd_first, cmd_data payload
//   core_opmode     {1'b0, continue, func} to the core
//   core_input_data block data to the core
//   core_textout    core result text, sampled on core_finished
//   core_finished   core completion pulse
//   rsp_valid/ready response handshake; rsp_func, rsp_text, rsp_err payload
//   busy            sequencer not idle
module xoodyak_cmd_sequencer #(
  parameter int DATA_W         = 352,
  parameter int TEXT_W         = 192,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              eph1,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_func,
  input  logic              cmd_first,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [5:0]        core_opmode,
  output logic [DATA_W-1:0] core_input_data,
  input  logic [TEXT_W-1:0] core_textout,
  input  logic              core_finished,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_func,
  output logic [TEXT_W-1:0] rsp_text,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] last_func;
  logic [7:0] tmo_cnt;
  logic       func_legal;
  logic       cont;
  logic       cmd_fire;
  logic       text_func;

  assign func_legal = (cmd_func != 4'd0) && (cmd_func <= 4'd7);

  // Continue only when the host chains another block of the same phase.
  // init always starts a fresh session.
  assign cont = ~cmd_first & (cmd_func == last_func) & (cmd_func != 4'd1);

  // Gated by reset so no command can be taken while reset is held.
  assign cmd_ready = (state == ST_IDLE) && reset;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // rsp_func holds the in-flight func while in WAIT.
  assign text_func = (rsp_func == 4'd4) || (rsp_func == 4'd5) || (rsp_func == 4'd6);

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      last_func       <= 4'd0;
      tmo_cnt         <= 8'd0;
      core_opmode     <= 6'd0;
      core_input_data <= '0;
      rsp_func        <= 4'd0;
      rsp_text        <= '0;
      rsp_err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            rsp_func <= cmd_func;
            if (func_legal) begin
              core_opmode     <= {1'b0, cont, cmd_func};
              core_input_data <= cmd_data;
              tmo_cnt         <= 8'd0;
              state           <= ST_WAIT;
            end else begin
              // Illegal func never reaches the core and leaves last_func alone.
              rsp_err  <= 1'b1;
              rsp_text <= '0;
              state    <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (core_finished) begin
            rsp_text    <= text_func ? core_textout : '0;
            rsp_err     <= 1'b0;
            last_func   <= rsp_func;
            core_opmode <= 6'd0;
            state       <= ST_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            // Core state is unknown after a hang, so the next command must not chain.
            rsp_err     <= 1'b1;
            rsp_text    <= '0;
            last_func   <= 4'd0;
            core_opmode <= 6'd0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          core_opmode <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xoodyak_cmd_sequencer.sv
module tb_xoodyak_cmd_sequencer;
  localparam int DW  = 352;
  localparam int TW  = 192;
  localparam int TMO = 64;

  logic          eph1 = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_func;
  logic          cmd_first;
  logic [DW-1:0] cmd_data;
  logic [5:0]    core_opmode;
  logic [DW-1:0] core_input_data;
  logic [TW-1:0] core_textout;
  logic          core_finished;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_func;
  logic [TW-1:0] rsp_text;
  logic          rsp_err;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] m_last;  // reference: func of last successfully completed command

  xoodyak_cmd_sequencer #(.DATA_W(DW), .TEXT_W(TW), .TIMEOUT_CYCLES(TMO)) dut (
    .eph1(eph1), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_first(cmd_first), .cmd_data(cmd_data),
    .core_opmode(core_opmode), .core_input_data(core_input_data),
    .core_textout(core_textout), .core_finished(core_finished),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_func(rsp_func),
    .rsp_text(rsp_text), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 eph1 = ~eph1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [TW-1:0] rnd_text();
    logic [TW-1:0] r;
    for (int k = 0; k < TW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge eph1);
    @(negedge eph1);
  endtask

  task automatic check_rsp(input string tag, input logic [3:0] f, input logic e, input logic [TW-1:0] t);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_func"}, rsp_func, f);
    check({tag, "_rsp_err"}, rsp_err, e);
    check({tag, "_rsp_text"}, rsp_text, t);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_opmode"}, core_opmode, 0);
  endtask

  // Issue a command. fin: cycle on which the core finishes (1..TMO), 0 = never.
  // hold: cycles the host keeps rsp_ready low before accepting.
  task automatic run_cmd(input logic [3:0] f, input logic first, input logic [DW-1:0] d,
                         input int fin, input logic [TW-1:0] txt, input int hold);
    logic legal, cont, timed_out, exp_err;
    logic [5:0] exp_op;
    logic [TW-1:0] exp_txt;
    int n_wait;
    legal     = (f >= 4'd1) && (f <= 4'd7);
    cont      = !first && (f == m_last) && (f != 4'd1);
    exp_op    = {1'b0, cont, f};
    timed_out = legal && !(fin >= 1 && fin <= TMO);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_func = f; cmd_first = first; cmd_data = d;
    tick();
    cmd_valid = 1'b0; cmd_data = rnd_data(); cmd_func = 4'($urandom); cmd_first = 1'($urandom);
    if (legal) begin
      n_wait = timed_out ? TMO : fin;
      for (int i = 0; i < n_wait; i++) begin
        check("wait_opmode", core_opmode, exp_op);
        check("wait_data", core_input_data, d);
        check("wait_rsp_valid", rsp_valid, 0);
        check("wait_cmd_ready", cmd_ready, 0);
        if (!timed_out && i == n_wait - 1) begin
          core_finished = 1'b1;
          core_textout  = txt;
        end else begin
          core_textout = rnd_text();
        end
        tick();
        core_finished = 1'b0;
        core_textout  = rnd_text();
      end
    end
    exp_err = !legal || timed_out;
    exp_txt = (!exp_err && f >= 4'd4 && f <= 4'd6) ? txt : '0;
    if (legal) m_last = timed_out ? 4'd0 : f;
    check_rsp("resp", f, exp_err, exp_txt);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      core_finished = 1'($urandom);  // stray completions must be ignored in RESP
      tick();
      core_finished = 1'b0;
      check_rsp("hold", f, exp_err, exp_txt);
    end
    // A command offered during the response handshake must not be taken.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_func = 4'd2; cmd_first = 1'b1;
    @(posedge eph1);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    check("post_opmode", core_opmode, 0);
    @(negedge eph1);
    check("post_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] f;
    int fin;
    reset = 1'b0; cmd_valid = 1'b0; cmd_func = 4'd0; cmd_first = 1'b0; cmd_data = '0;
    core_textout = '0; core_finished = 1'b0; rsp_ready = 1'b0;
    m_last = 4'd0;
    repeat (3) @(negedge eph1);
    check("rst_opmode", core_opmode, 0);
    check("rst_data", core_input_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_func", rsp_func, 0);
    check("rst_rsp_text", rsp_text, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();
    check("rel_cmd_ready", cmd_ready, 1);

    // init
    run_cmd(4'd1, 1'b1, {128'h38393a3b3c3d3e3f3031323334353637, 224'h0}, 12, rnd_text(), 0);
    // two chained assoc blocks: 6'h03 then 6'h13
    run_cmd(4'd3, 1'b1, 352'h6162636465666768696a6b6c, 12, rnd_text(), 1);
    run_cmd(4'd3, 1'b0, 352'h6162636465666768696a6b6c, 12, rnd_text(), 0);
    // crypt with text capture and a 5-cycle response stall
    run_cmd(4'd4, 1'b1, rnd_data(), 7, 192'h87a06d5561b0d87c20a12db5d34783258ff75fe5d87c0e30, 5);
    // squeeze that never finishes, then a squeeze that must not chain
    run_cmd(4'd6, 1'b1, rnd_data(), 0, rnd_text(), 0);
    run_cmd(4'd6, 1'b0, rnd_data(), 3, rnd_text(), 0);
    // finished on the timeout cycle wins
    run_cmd(4'd5, 1'b0, rnd_data(), TMO, rnd_text(), 0);
    // illegal func
    run_cmd(4'hA, 1'b0, rnd_data(), 4, rnd_text(), 2);

    // complete a decrypt, then abort a second decrypt by reset in WAIT
    run_cmd(4'd5, 1'b1, rnd_data(), 4, rnd_text(), 0);
    cmd_valid = 1'b1; cmd_func = 4'd5; cmd_first = 1'b0; cmd_data = rnd_data();
    tick();
    cmd_valid = 1'b0;
    check("abort_opmode_chained", core_opmode, 6'h15);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("abort_opmode", core_opmode, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    @(negedge eph1);
    reset = 1'b1;
    m_last = 4'd0;
    #1;
    check("abort_cmd_ready", cmd_ready, 1);
    @(negedge eph1);
    run_cmd(4'd5, 1'b0, rnd_data(), 5, rnd_text(), 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) f = 4'($urandom);
      else f = 4'($urandom_range(1, 7));
      case ($urandom_range(0, 9))
        0:       fin = 0;
        1:       fin = TMO;
        default: fin = $urandom_range(1, 20);
      endcase
      run_cmd(f, 1'($urandom_range(0, 3) == 0), rnd_data(), fin, rnd_text(), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xoodyak_cmd_sequencer.md
Name: xoodyak_cmd_sequencer

Overview:
- Host-side command sequencer that drives the opmode / input_data interface of `xoodyak_build` and collects its `textout` / `finished` results.
- Accepts one command at a time through a valid/ready handshake, holds opmode and data stable until the core reports completion, and returns the result on a valid/ready response channel.
- Generates the continue bit automatically and guards against a hung core with a timeout.
- Sits between the host bus adapter and the Xoodyak core, replacing hand-built opmode sequences.

Parameters:
- DATA_W, 352, width of the core input_data bus.
- TEXT_W, 192, width of the core textout bus.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT without `core_finished` before an error response (valid range 2..255).

Ports:
- eph1  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  host command valid
- cmd_ready  output  1  sequencer can accept a command
- cmd_func  input  4  1 init, 2 nonce, 3 assoc, 4 crypt, 5 decrypt, 6 squeeze, 7 ratchet
- cmd_first  input  1  start of a new phase; forces continue=0
- cmd_data  input  DATA_W  block data for the core
- core_opmode  output  6  [3:0] func, [4] continue, [5] tied 0
- core_input_data  output  DATA_W  data to core
- core_textout  input  TEXT_W  core result text
- core_finished  input  1  core completion pulse
- rsp_valid  output  1  response valid
- rsp_ready  input  1  host accepts response
- rsp_func  output  4  func of the completed command
- rsp_text  output  TEXT_W  captured text (funcs 4/5/6), else 0
- rsp_err  output  1  timeout or illegal func
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset low, asynchronous) takes effect immediately:
  - state=IDLE, last_func=0, timeout counter=0.
  - core_opmode=0, core_input_data=0.
  - rsp_valid=0, rsp_func=0, rsp_text=0, rsp_err=0.
  - cmd_ready=1 once reset is released, busy=0.
- Reset asserted mid-operation aborts the operation; no response is produced and the core sees opmode 0 on the same cycle.
- States: IDLE, WAIT, RESP.
- IDLE:
  - cmd_ready=1, core_opmode=0.
  - On cmd_valid & cmd_ready with legal func (1..7), at that edge:
    - core_opmode <= {1'b0, cont, cmd_func}
    - core_input_data <= cmd_data
    - rsp_func <= cmd_func, counter <= 0, go to WAIT.
  - cont = ~cmd_first & (cmd_func == last_func) & (cmd_func != 1).
  - Illegal func (0, 8..15): accepted, no core issue; rsp_func <= cmd_func, rsp_err <= 1, rsp_text <= 0; go to RESP (rsp_valid high the next cycle).
- WAIT:
  - cmd_ready=0; core_opmode and core_input_data held constant.
  - The counter increments every cycle.
  - On core_finished:
    - rsp_text <= (func in {4,5,6}) ? core_textout : 0
    - rsp_err <= 0, last_func <= func
    - core_opmode <= 0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without core_finished:
    - rsp_err <= 1, rsp_text <= 0, last_func <= 0
    - core_opmode <= 0, go to RESP.
  - finished and timeout on the same cycle: finished wins.
- RESP:
  - rsp_valid=1; rsp_* stable while rsp_ready=0; cmd_ready=0; core_opmode=0.
  - On rsp_ready go to IDLE; rsp_valid drops the next cycle.
  - A new command cannot be accepted in the same cycle as the response handshake (one idle cycle minimum between commands).
- core_finished in IDLE or RESP is ignored and has no state effect.
- Latency: the opmode appears the cycle after the command handshake; rsp_valid asserts the cycle after core_finished.

Test Plan:
- Reset release, then cmd func=1, first=1, data={128'h38393a3b3c3d3e3f3031323334353637, 224'h0}; core_finished after 12 cycles -> core_opmode=6'h01 for 12 cycles then 0; rsp_valid with func=1, err=0, text=0.
- Two assoc commands: first=1 then first=0, data 352'h6162...6c; each finished after 12 cycles -> opmode 6'h03 then 6'h13; both rsp err=0.
- Crypt func=4 with core_textout=192'h87a06d5561b0d87c20a12db5d34783258ff75fe5d87c0e30 at finished -> rsp_text equals that value; hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0 throughout.
- Squeeze func=6 with core_finished never asserted, TIMEOUT_CYCLES=64 -> opmode 6'h06 held for 64 cycles, then opmode=0, rsp_err=1, rsp_text=0; a following func=6 first=0 command issues opmode 6'h06 (continue cleared).
- Illegal func=4'hA -> core_opmode stays 0; rsp_valid the next cycle, rsp_func=4'hA, rsp_err=1.
- Assert reset in WAIT cycle 3 of a decrypt (func=5) -> opmode=0, rsp_valid=0 immediately; after release cmd_ready=1 and last_func=0, so func=5 first=0 issues 6'h05.
